twowire_apb_arbiter: RTL
========================

TWOWIRE_APB_ARBITER -- requirements
Module: twowire_apb_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of upstream APB3 requesters (legal 2..8).
REQ-002 SHALL have parameter W_ADDR, default 8, downstream address width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, access-phase wait limit; used only when timeout is compiled in.
REQ-004 SHALL have port dck, input, 1, the single clock.
REQ-005 SHALL have port drst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports up_psel, up_penable, up_pwrite, inputs, N_MASTERS each, per-master APB3 controls.
REQ-007 SHALL have ports up_paddr (N_MASTERS*W_ADDR) and up_pwdata (N_MASTERS*32), inputs, flat per-master vectors with master i at slice i.
REQ-008 SHALL have ports up_pready and up_pslverr (N_MASTERS each) and up_prdata (32, shared), outputs, per-master responses.
REQ-009 SHALL have ports dst_psel, dst_penable, dst_pwrite (1 each), dst_paddr (W_ADDR) and dst_pwdata (32), outputs, downstream APB3 request.
REQ-010 SHALL have ports dst_pready and dst_pslverr (1 each) and dst_prdata (32), inputs, downstream APB3 response.
REQ-011 SHALL have port grant, output, $clog2(N_MASTERS), index of the current or last granted master.
REQ-012 SHALL have port busy, output, 1, high in states SETUP and ACCESS.

Function
REQ-013 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-014 IDLE: if any up_psel bit is set, SHALL latch the winner into grant and go to SETUP next cycle; otherwise SHALL stay in IDLE.
REQ-015 Winner SHALL be the first requester found scanning from grant+1 modulo N_MASTERS upward (round-robin); a lone requester SHALL win regardless of pointer.
REQ-016 SETUP: dst_psel=1, dst_penable=0; SHALL go to ACCESS unconditionally.
REQ-017 ACCESS: dst_psel=1, dst_penable=1; on dst_pready=1 SHALL go to IDLE.
REQ-018 dst_paddr, dst_pwdata and dst_pwrite SHALL be combinational muxes of the granted master's inputs; all are 0 in IDLE.
REQ-019 up_pready[grant] SHALL equal dst_pready in ACCESS only; all other up_pready bits SHALL be 0, stalling losers.
REQ-020 up_pslverr[grant] SHALL equal dst_pslverr && dst_pready in ACCESS; otherwise 0.
REQ-021 up_prdata SHALL equal dst_prdata in ACCESS; otherwise 0.
REQ-022 Minimum transfer latency: psel at cycle 0 gives dst_psel at cycle 1 and earliest up_pready at cycle 2.
REQ-023 Back-to-back: the IDLE cycle after a completion SHALL perform arbitration, so a pending loser enters SETUP 2 cycles after the winner's completion.
REQ-024 Simultaneous requests SHALL be resolved in one cycle with no starvation; each requester is granted within N_MASTERS transfers.
REQ-025 If the granted master drops up_psel before completion (protocol violation), the downstream transfer SHALL still complete normally, with the response discarded.

Reset
REQ-026 drst high at a clock edge SHALL force IDLE, grant=N_MASTERS-1, busy=0 and all dst_* outputs and up_* outputs to 0, including mid-transfer (abandoned).

Configuration
REQ-027 With TWOWIRE_ARB_TIMEOUT_EN defined, a counter SHALL clear on SETUP and increment each ACCESS cycle with dst_pready=0.
REQ-028 With TWOWIRE_ARB_TIMEOUT_EN defined, when that count reaches TIMEOUT_CYCLES the block SHALL assert up_pready[grant]=1, up_pslverr[grant]=1 and up_prdata=0 for one cycle, and return to IDLE with dst_psel dropped.
REQ-029 Without TWOWIRE_ARB_TIMEOUT_EN, the block SHALL have no counter and ACCESS SHALL wait indefinitely for dst_pready.

Structure
REQ-030 Shared package twowire_arb_pkg SHALL hold the FSM state encodings (IDLE=0, SETUP=1, ACCESS=2) and the timeout counter width constant.
REQ-031 Round-robin selection SHALL live in combinational sub-module twowire_rr_pick (inputs: req vector, pointer; output: winner index, valid).

Verification
REQ-032 Single request: master 0 writes addr 0x12, data 0xCAFEF00D, dst_pready=1 in ACCESS -> dst_psel at cycle 1, dst_penable at cycle 2, up_pready[0]=1 at cycle 2, dst_paddr=0x12.
REQ-033 Contention: masters 0 and 1 request at the same cycle after reset -> master 0 granted first and master 1 enters SETUP 2 cycles after master 0's up_pready; up_pready[1]=0 throughout master 0's transfer.
REQ-034 Fairness: both masters request continuously for 6 transfers -> grant sequence 0,1,0,1,0,1.
REQ-035 Error: master 1 reads, dst_pslverr=1 with dst_pready -> up_pslverr[1]=1 for one cycle and up_prdata=dst_prdata.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=4): dst_pready held 0 -> up_pready=1, up_pslverr=1, up_prdata=0 after 4 ACCESS cycles, and dst_psel=0 the next cycle.
REQ-037 Reset mid-ACCESS: drst asserted for 1 cycle -> all outputs 0 the next cycle, and a subsequent request from master 1 alone is granted.

Source files
------------

// File: rtl/twowire_arb_pkg.sv
// twowire_arb_pkg -- shared definitions for the two-wire APB3 arbiter.
//   arb_state_t : FSM state encoding (IDLE=0, SETUP=1, ACCESS=2)
//   TO_CNT_W    : width of the optional access-phase timeout counter
package twowire_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    // Wide enough for any practical TIMEOUT_CYCLES (up to 65535).
    localparam int TO_CNT_W = 16;

endpackage

// File: rtl/twowire_apb_arbiter_if.sv
// twowire_apb_arbiter_if -- one APB3 channel (request + response).
//   master modport : drives psel/penable/pwrite/paddr/pwdata, receives response
//   slave modport  : receives request, drives prdata/pready/pslverr
// Used to bundle the downstream channel of twowire_apb_arbiter at the
// system level.
interface twowire_apb_arbiter_if #(
    parameter int W_ADDR = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [W_ADDR-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/twowire_rr_pick.sv
// twowire_rr_pick -- combinational round-robin selector.
//   req   : request vector, one bit per master
//   ptr   : index of the last granted master
//   win   : first requester found scanning upward from ptr+1 (mod N)
//   valid : at least one request present
module twowire_rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          valid
);
    localparam int DW = IW + 1;

    logic [DW-1:0] best_d;
    logic [DW-1:0] d;

    // Each requester gets a distance from ptr+1; the smallest distance wins.
    // A lone requester always wins since every real distance is < N.
    always_comb begin
        win    = ptr;
        valid  = |req;
        best_d = '1;
        d      = '0;
        for (int i = 0; i < N; i++) begin
            d = DW'((i + N - 1 - int'(ptr)) % N);
            if (req[i] && (d < best_d)) begin
                best_d = d;
                win    = IW'(i);
            end
        end
    end
endmodule

// File: rtl/twowire_apb_arbiter.sv
// twowire_apb_arbiter -- N-master to one-slave APB3 arbiter, round-robin.
//   dck, drst            : clock, synchronous active-high reset
//   up_psel/penable/pwrite, up_paddr, up_pwdata : per-master requests (flat)
//   up_pready, up_pslverr, up_prdata            : per-master responses
//   dst_*                : downstream APB3 request / response
//   grant                : current or last granted master index
//   busy                 : high while in SETUP or ACCESS
// Optional feature macro: TWOWIRE_ARB_TIMEOUT_EN -- abort an ACCESS phase
// with an error response after TIMEOUT_CYCLES wait cycles.
module twowire_apb_arbiter
    import twowire_arb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int W_ADDR         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          dck,
    input  logic                          drst,
    input  logic [N_MASTERS-1:0]          up_psel,
    input  logic [N_MASTERS-1:0]          up_penable,
    input  logic [N_MASTERS-1:0]          up_pwrite,
    input  logic [N_MASTERS*W_ADDR-1:0]   up_paddr,
    input  logic [N_MASTERS*32-1:0]       up_pwdata,
    output logic [N_MASTERS-1:0]          up_pready,
    output logic [N_MASTERS-1:0]          up_pslverr,
    output logic [31:0]                   up_prdata,
    output logic                          dst_psel,
    output logic                          dst_penable,
    output logic                          dst_pwrite,
    output logic [W_ADDR-1:0]             dst_paddr,
    output logic [31:0]                   dst_pwdata,
    input  logic                          dst_pready,
    input  logic                          dst_pslverr,
    input  logic [31:0]                   dst_prdata,
    output logic [$clog2(N_MASTERS)-1:0]  grant,
    output logic                          busy
);
    localparam int GW = $clog2(N_MASTERS);

    arb_state_t    state, state_nx;
    logic [GW-1:0] grant_nx;
    logic [GW-1:0] pick;
    logic          pick_vld;
    logic          timeout;

    // Masters' penable is not needed: the grant is taken on psel alone.
    logic unused_penable;
    assign unused_penable = ^up_penable;

    twowire_rr_pick #(.N(N_MASTERS), .IW(GW)) u_pick (
        .req   (up_psel),
        .ptr   (grant),
        .win   (pick),
        .valid (pick_vld)
    );

    always_ff @(posedge dck) begin
        if (drst) begin
            state <= ST_IDLE;
            grant <= GW'(N_MASTERS - 1);   // first scan starts at master 0
        end else begin
            state <= state_nx;
            grant <= grant_nx;
        end
    end

`ifdef TWOWIRE_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] wait_cnt;

    always_ff @(posedge dck) begin
        if (drst || state == ST_SETUP)
            wait_cnt <= '0;
        else if (state == ST_ACCESS && !dst_pready && !timeout)
            wait_cnt <= wait_cnt + TO_CNT_W'(1);
    end

    // A late pready on the limit cycle still completes normally.
    assign timeout = (state == ST_ACCESS) && !dst_pready &&
                     (wait_cnt == TO_CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nx = ST_SETUP;
                    grant_nx = pick;
                end
            end
            ST_SETUP:  state_nx = ST_ACCESS;
            // Completion ignores the master's psel: an abandoned transfer
            // still finishes downstream and its response is simply dropped.
            ST_ACCESS: if (dst_pready || timeout) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        dst_psel    = busy;
        dst_penable = (state == ST_ACCESS);
        dst_paddr   = '0;
        dst_pwdata  = '0;
        dst_pwrite  = 1'b0;
        up_pready   = '0;
        up_pslverr  = '0;
        up_prdata   = '0;
        if (busy) begin
            dst_paddr  = up_paddr[int'(grant)*W_ADDR +: W_ADDR];
            dst_pwdata = up_pwdata[int'(grant)*32 +: 32];
            dst_pwrite = up_pwrite[grant];
        end
        if (state == ST_ACCESS) begin
            up_pready[grant]  = dst_pready | timeout;
            up_pslverr[grant] = (dst_pslverr & dst_pready) | timeout;
            if (!timeout) up_prdata = dst_prdata;
        end
    end
endmodule
